// File: rtl/gru_seq_ctrl_pkg.sv
// gru_pkg: shared element type, width defaults and sequencer state encoding
// for the GRU sequence controller slice.
package gru_pkg;

   localparam int DEF_DATA_WIDTH = 15;
   localparam int DEF_FRAC_BITS  = 9;

   typedef logic signed [DEF_DATA_WIDTH-1:0] fx_t;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_X,
      START,
      WAIT,
      EMIT
   } seq_state_e;

endpackage

// File: rtl/gru_vec_serializer.sv
// gru_vec_serializer: loads an N-element vector and streams it out element 0
// first, one element per valid/ready handshake (N >= 2).
module gru_vec_serializer #(
   parameter int N = 16,
   parameter int W = 15
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                load,
   input  logic [N-1:0][W-1:0] vec,
   input  logic                h_ready,
   output logic                h_valid,
   output logic [W-1:0]        h_data,
   output logic                h_last,
   output logic                last_hs
);

   localparam int CNT_W = (N > 2) ? $clog2(N) : 1;

   logic [N-1:0][W-1:0] shreg;
   logic [CNT_W-1:0]    cnt;

   // Element on the output is always the bottom of the shift register.
   assign h_data  = shreg[0];
   assign last_hs = h_valid & h_ready & h_last;

   always_ff @(posedge clk) begin
      if (rst) begin
         shreg   <= '0;
         cnt     <= '0;
         h_valid <= 1'b0;
         h_last  <= 1'b0;
      end else if (load) begin
         shreg   <= vec;
         cnt     <= '0;
         h_valid <= 1'b1;
         h_last  <= 1'b0;
      end else if (h_valid && h_ready) begin
         shreg <= {{W{1'b0}}, shreg[N-1:1]};
         if (h_last) begin
            h_valid <= 1'b0;
            h_last  <= 1'b0;
            cnt     <= '0;
         end else begin
            h_last <= (cnt == CNT_W'(N-2));
            cnt    <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/gru_seq_ctrl.sv
// gru_seq_ctrl: drives a gru_cell_parallel over seq_len timesteps, feeding h_t back
// as h_prev. Define GRU_SEQ_EMIT_ALL_EN to stream every timestep's h_t, not only the last.
//
// state  | meaning
// IDLE   | waiting for seq_start
// LOAD_X | deserialising D input elements into cell_x_t
// START  | one-cycle cell_start
// WAIT   | waiting for cell_done; h_t captured on done
// EMIT   | streaming the hidden state out
module gru_seq_ctrl
   import gru_pkg::*;
#(
   parameter int D          = 64,
   parameter int H          = 16,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int FRAC_BITS  = DEF_FRAC_BITS,
   parameter int LEN_W      = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         seq_start,
   input  logic [LEN_W-1:0]             seq_len,
   input  logic                         x_valid,
   input  logic signed [DATA_WIDTH-1:0] x_data,
   output logic                         x_ready,
   output logic                         cell_start,
   output logic [D-1:0][DATA_WIDTH-1:0] cell_x_t,
   output logic [H-1:0][DATA_WIDTH-1:0] cell_h_prev,
   input  logic [H-1:0][DATA_WIDTH-1:0] cell_h_t,
   input  logic                         cell_done,
   output logic                         h_valid,
   output logic [DATA_WIDTH-1:0]        h_data,
   output logic                         h_last,
   input  logic                         h_ready,
   output logic                         busy,
   output logic                         seq_done
);

   localparam int IDX_W = $clog2((D > H) ? D : H);
`ifdef GRU_SEQ_EMIT_ALL_EN
   localparam bit EMIT_ALL = 1'b1;
`else
   localparam bit EMIT_ALL = 1'b0;
`endif

   // Fixed-point format only matters to the cell; reject a nonsensical pairing early.
   if (FRAC_BITS >= DATA_WIDTH) begin : g_frac_chk
      $error("FRAC_BITS must be smaller than DATA_WIDTH");
   end

   seq_state_e                  state;
   logic [LEN_W-1:0]            len_q;
   logic [LEN_W-1:0]            t;
   logic [IDX_W-1:0]            idx;
   logic                        last_step;
   logic                        ser_load;
   logic                        ser_last_hs;
   logic [H-1:0][DATA_WIDTH-1:0] ser_vec;

   assign last_step = (t == len_q - LEN_W'(1));
   assign busy      = (state != IDLE);

   // The serializer loads in the same cycle the FSM moves to EMIT, so it sees the
   // value cell_h_prev is about to take rather than the stale register.
   always_comb begin
      ser_load = 1'b0;
      ser_vec  = cell_h_t;
      if (state == IDLE && seq_start && seq_len == '0) begin
         ser_load = !EMIT_ALL;
         ser_vec  = '0;
      end else if (state == WAIT && cell_done) begin
         ser_load = EMIT_ALL || last_step;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         len_q       <= '0;
         t           <= '0;
         idx         <= '0;
         x_ready     <= 1'b0;
         cell_start  <= 1'b0;
         seq_done    <= 1'b0;
         cell_x_t    <= '0;
         cell_h_prev <= '0;
      end else begin
         seq_done   <= 1'b0;
         cell_start <= 1'b0;
         case (state)
            IDLE: begin
               if (seq_start) begin
                  len_q       <= seq_len;
                  t           <= '0;
                  idx         <= '0;
                  cell_h_prev <= '0;
                  if (seq_len == '0) begin
                     if (EMIT_ALL) seq_done <= 1'b1;
                     else          state    <= EMIT;
                  end else begin
                     x_ready <= 1'b1;
                     state   <= LOAD_X;
                  end
               end
            end
            LOAD_X: begin
               if (x_valid) begin
                  cell_x_t[idx] <= x_data;
                  if (idx == IDX_W'(D-1)) begin
                     idx        <= '0;
                     x_ready    <= 1'b0;
                     cell_start <= 1'b1;
                     state      <= START;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
            START: state <= WAIT;
            WAIT: begin
               if (cell_done) begin
                  cell_h_prev <= cell_h_t;
                  if (EMIT_ALL || last_step) begin
                     state <= EMIT;
                  end else begin
                     t       <= t + 1'b1;
                     x_ready <= 1'b1;
                     state   <= LOAD_X;
                  end
               end
            end
            EMIT: begin
               if (ser_last_hs) begin
                  if (EMIT_ALL && !last_step) begin
                     t       <= t + 1'b1;
                     x_ready <= 1'b1;
                     state   <= LOAD_X;
                  end else begin
                     seq_done <= 1'b1;
                     state    <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   gru_vec_serializer #(
      .N (H),
      .W (DATA_WIDTH)
   ) u_ser (
      .clk     (clk),
      .rst     (rst),
      .load    (ser_load),
      .vec     (ser_vec),
      .h_ready (h_ready),
      .h_valid (h_valid),
      .h_data  (h_data),
      .h_last  (h_last),
      .last_hs (ser_last_hs)
   );

endmodule

// File: tb/tb_gru_seq_ctrl.sv
// Self-checking bench for gru_seq_ctrl: behavioural cell, sequence-level reference
// model feeding scoreboard queues, and a monitor that checks every output event.
`timescale 1ns/1ps
module tb_gru_seq_ctrl;
   import gru_pkg::*;

   localparam int D      = 64;
   localparam int H      = 16;
   localparam int DW     = DEF_DATA_WIDTH;
   localparam int LEN_W  = 8;
   localparam int MAXLEN = 6;
`ifdef GRU_SEQ_EMIT_ALL_EN
   localparam bit EMIT_ALL = 1'b1;
`else
   localparam bit EMIT_ALL = 1'b0;
`endif

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 seq_start;
   logic [LEN_W-1:0]     seq_len;
   logic                 x_valid;
   fx_t                  x_data;
   logic                 x_ready;
   logic                 cell_start;
   logic [D-1:0][DW-1:0] cell_x_t;
   logic [H-1:0][DW-1:0] cell_h_prev;
   logic [H-1:0][DW-1:0] cell_h_t;
   logic                 cell_done;
   logic                 h_valid;
   logic [DW-1:0]        h_data;
   logic                 h_last;
   logic                 h_ready;
   logic                 busy;
   logic                 seq_done;

   gru_seq_ctrl #(
      .D(D), .H(H), .DATA_WIDTH(DW), .FRAC_BITS(DEF_FRAC_BITS), .LEN_W(LEN_W)
   ) dut (
      .clk(clk), .rst(rst), .seq_start(seq_start), .seq_len(seq_len),
      .x_valid(x_valid), .x_data(x_data), .x_ready(x_ready),
      .cell_start(cell_start), .cell_x_t(cell_x_t), .cell_h_prev(cell_h_prev),
      .cell_h_t(cell_h_t), .cell_done(cell_done),
      .h_valid(h_valid), .h_data(h_data), .h_last(h_last), .h_ready(h_ready),
      .busy(busy), .seq_done(seq_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] data;
      logic          last;
      logic          done_after;
   } out_t;

   typedef struct {
      logic [D-1:0][DW-1:0] x;
      logic [H-1:0][DW-1:0] hp;
   } start_t;

   out_t   out_q[$];
   start_t start_q[$];

   int vecs      = 0;
   int errs      = 0;
   int cyc       = 0;
   int done_at   = -1;
   int n_starts  = 0;
   int n_last    = 0;
   int n_done    = 0;
   int cell_mode = 0;
   int ready_mode = 0;
   int stall_left = 0;

   logic [DW-1:0]        xs [MAXLEN][D];
   logic [H-1:0][DW-1:0] nh;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Cell: mode 0 is h_t[i] = h_prev[i] + x_t[0]; mode 1 adds x_t[i] so the
   // hidden elements differ and ordering errors show up. Done after 3 cycles.
   initial begin
      cell_done = 1'b0;
      cell_h_t  = '0;
      forever begin
         @(negedge clk);
         if (cell_start && !rst) begin
            for (int i = 0; i < H; i++)
               nh[i] = cell_h_prev[i] + ((cell_mode != 0) ? cell_x_t[i] : cell_x_t[0]);
            repeat (2) @(negedge clk);
            cell_h_t  = nh;
            cell_done = 1'b1;
            @(negedge clk);
            cell_done = 1'b0;
         end
      end
   end

   initial begin
      h_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (ready_mode == 0) begin
            h_ready = 1'b1;
         end else if (stall_left > 0) begin
            h_ready = 1'b0;
            stall_left--;
         end else if (h_valid && $urandom_range(3) == 0) begin
            h_ready    = 1'b0;
            stall_left = 4;
         end else begin
            h_ready = 1'($urandom_range(1));
         end
      end
   end

   // Monitor: checks every presented element, seq_done timing and cell_start contents.
   always @(negedge clk) begin
      if (!rst) begin
         if (h_valid) begin
            if (out_q.size() == 0) begin
               vecs++; errs++;
               $display("FAIL unexpected_h: h_data=%0h presented with nothing expected", h_data);
            end else begin
               check("h_data", 64'(h_data), 64'(out_q[0].data));
               check("h_last", 64'(h_last), 64'(out_q[0].last));
               if (h_ready) begin
                  if (h_last) n_last++;
                  if (out_q[0].done_after) done_at = cyc + 1;
                  void'(out_q.pop_front());
               end
            end
         end
         if (seq_done || cyc == done_at) begin
            check("seq_done", 64'(seq_done), 64'(cyc == done_at));
            if (seq_done) n_done++;
         end
         if (cell_start) begin
            n_starts++;
            if (start_q.size() == 0) begin
               vecs++; errs++;
               $display("FAIL unexpected_cell_start: got a pulse, expected none");
            end else begin
               vecs++;
               if (cell_x_t !== start_q[0].x) begin
                  errs++;
                  $display("FAIL cell_x_t: got x0=%0h xlast=%0h, expected x0=%0h xlast=%0h",
                           cell_x_t[0], cell_x_t[D-1], start_q[0].x[0], start_q[0].x[D-1]);
               end
               vecs++;
               if (cell_h_prev !== start_q[0].hp) begin
                  errs++;
                  $display("FAIL cell_h_prev: got h0=%0h h15=%0h, expected h0=%0h h15=%0h",
                           cell_h_prev[0], cell_h_prev[H-1], start_q[0].hp[0], start_q[0].hp[H-1]);
               end
               void'(start_q.pop_front());
            end
         end
      end
   end

   task automatic push_burst(input logic [H-1:0][DW-1:0] h, input bit final_burst);
      out_t o;
      for (int i = 0; i < H; i++) begin
         o.data       = h[i];
         o.last       = (i == H-1);
         o.done_after = final_burst && (i == H-1);
         out_q.push_back(o);
      end
   endtask

   task automatic check_idle_zero(input string tag);
      check({tag, "_busy"},        64'(busy), 0);
      check({tag, "_x_ready"},     64'(x_ready), 0);
      check({tag, "_cell_start"},  64'(cell_start), 0);
      check({tag, "_h_valid"},     64'(h_valid), 0);
      check({tag, "_h_last"},      64'(h_last), 0);
      check({tag, "_seq_done"},    64'(seq_done), 0);
      check({tag, "_h_data"},      64'(h_data), 0);
      check({tag, "_x_t_zero"},    64'(cell_x_t == '0), 1);
      check({tag, "_h_prev_zero"}, 64'(cell_h_prev == '0), 1);
   endtask

   task automatic run_seq(input int len, input bit fixed, input int x0,
                          input int gap_pct, input bit abort);
      logic [H-1:0][DW-1:0] h;
      start_t s;
      int st0, dn0, lst0, j, budget;
      for (int t = 0; t < len; t++)
         for (int k = 0; k < D; k++)
            xs[t][k] = fixed ? ((k == 0) ? DW'(x0) : DW'(k + 1)) : DW'($urandom);
      // Reference: h accumulates per timestep from zero, in element order.
      h = '0;
      for (int t = 0; t < len; t++) begin
         for (int k = 0; k < D; k++) s.x[k] = xs[t][k];
         s.hp = h;
         start_q.push_back(s);
         for (int i = 0; i < H; i++)
            h[i] = h[i] + ((cell_mode != 0) ? xs[t][i] : xs[t][0]);
         if (EMIT_ALL) push_burst(h, t == len-1);
      end
      if (!EMIT_ALL) push_burst(h, 1'b1);

      st0 = n_starts; dn0 = n_done; lst0 = n_last;
      @(negedge clk);
      seq_start = 1'b1;
      seq_len   = LEN_W'(len);
      if (EMIT_ALL && len == 0) done_at = cyc + 1;
      @(negedge clk);
      seq_start = 1'b0;
      check("busy_after_start", 64'(busy), 64'(!(EMIT_ALL && len == 0)));
      for (int t = 0; t < len; t++) begin
         j = 0; budget = 0;
         while (j < D) begin
            seq_start = ($urandom_range(7) == 0);
            seq_len   = LEN_W'($urandom);
            x_valid   = ($urandom_range(99) >= gap_pct);
            x_data    = x_valid ? fx_t'(xs[t][j]) : fx_t'($urandom);
            if (x_valid && x_ready) j++;
            @(negedge clk);
            budget++;
            if (budget > 5000) begin
               check("x_load_timeout", 64'(j), 64'(D));
               seq_start = 1'b0; x_valid = 1'b0;
               return;
            end
         end
         seq_start = 1'b0;
         x_valid   = 1'b0;
         if (abort) begin
            budget = 0;
            while (!cell_start && budget < 20) begin
               @(negedge clk);
               budget++;
            end
            check("abort_saw_start", 64'(cell_start), 1);
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            out_q.delete();
            start_q.delete();
            done_at = -1;
            return;
         end
      end
      budget = 0;
      while (n_done == dn0 && budget < 4000) begin
         @(negedge clk);
         budget++;
      end
      check("seq_done_seen", 64'(n_done - dn0), 1);
      check("cell_start_count", 64'(n_starts - st0), 64'(len));
      check("h_last_count", 64'(n_last - lst0), 64'(EMIT_ALL ? len : 1));
      check("out_queue_drained", 64'(out_q.size()), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; seq_start = 1'b0; seq_len = '0; x_valid = 1'b0; x_data = '0;
      repeat (3) @(negedge clk);
      check_idle_zero("reset");
      rst = 1'b0;

      cell_mode = 0; ready_mode = 0;
      run_seq(1, 1'b1, 1, 0, 1'b0);
      run_seq(3, 1'b1, 2, 0, 1'b0);
      run_seq(2, 1'b1, 3, 0, 1'b0);
      ready_mode = 1;
      run_seq(3, 1'b1, 5, 50, 1'b0);
      ready_mode = 0;
      run_seq(0, 1'b1, 0, 0, 1'b0);
      run_seq(1, 1'b0, 0, 0, 1'b1);
      repeat (4) @(negedge clk);
      check_idle_zero("abort");
      run_seq(1, 1'b0, 0, 0, 1'b0);

      cell_mode = 1;
      for (int k = 0; k < 6; k++) begin
         ready_mode = $urandom_range(1);
         run_seq($urandom_range(4), 1'b0, 0, $urandom_range(60), 1'b0);
      end
      run_seq(0, 1'b0, 0, 0, 1'b0);

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
